tile_loader: RTL and testbench

- Producer side of the A/W buffer write port.
- Reads a row-major 8-bit matrix tile from a word-addressed BRAM (one element per 32-bit word, in the low byte).
- Scatters the tile into the ARRAY_N banked buffer RAMs as a write address, one-hot bank enable and data.
- Sits between the system BRAM and the bram_to_a_ram_w_* / bram_to_w_ram_w_* inputs of the systolic system; one instance per buffer.

---
 rtl/tile_loader_pkg.sv | 16 +
 rtl/tile_addr_gen.sv | 123 ++++++++++++
 rtl/tile_loader.sv | 149 ++++++++++++++
 tb/tb_tile_loader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_loader_pkg.sv
`default_nettype none
// tile_loader_pkg: FSM state encoding and read-to-write pipeline depth shared by tile_loader.
// Rev 1.0
package tile_loader_pkg;

  localparam int PIPE_LAT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/tile_addr_gen.sv
`default_nettype none
// tile_addr_gen: row/column walker producing BRAM source address, bank address, lane and last flag.
// Rev 1.0
module tile_addr_gen
  import tile_loader_pkg::*;
#(
  parameter int ARRAY_N         = 16,
  parameter int RAM_SIZE        = 1024,
  parameter int ADDR_WIDTH      = $clog2(RAM_SIZE),
  parameter int BRAM_ADDR_WIDTH = 32,
  parameter int DIM_WIDTH       = 16,
  parameter int LANE_W          = (ARRAY_N > 1) ? $clog2(ARRAY_N) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_i,
  input  logic                       step_i,
  input  logic                       xpose_i,
  input  logic [BRAM_ADDR_WIDTH-1:0] src_base_i,
  input  logic [DIM_WIDTH-1:0]       src_stride_i,
  input  logic [ADDR_WIDTH-1:0]      dst_base_i,
  input  logic [DIM_WIDTH-1:0]       rows_i,
  input  logic [DIM_WIDTH-1:0]       cols_i,
  output logic [BRAM_ADDR_WIDTH-1:0] src_addr_o,
  output logic [ADDR_WIDTH-1:0]      dst_addr_o,
  output logic [LANE_W-1:0]          lane_o,
  output logic                       last_o
);

  logic [DIM_WIDTH-1:0]       row_q, row_d, col_q, col_d;
  logic [DIM_WIDTH-1:0]       rows_q, rows_d, cols_q, cols_d;
  logic [DIM_WIDTH-1:0]       stride_q, stride_d;
  logic [BRAM_ADDR_WIDTH-1:0] row_base_q, row_base_d, src_addr_q, src_addr_d;
  logic [ADDR_WIDTH-1:0]      dst_base_q, dst_base_d;
  logic [ADDR_WIDTH-1:0]      dst_row_q, dst_row_d, dst_col_q, dst_col_d;
  logic                       xpose_q, xpose_d;
  logic                       col_last;
  logic [BRAM_ADDR_WIDTH-1:0] stride_ext;

  // Bank addresses wrap at RAM_SIZE even when it is not a power of two.
  function automatic logic [ADDR_WIDTH-1:0] bank_inc(input logic [ADDR_WIDTH-1:0] a);
    if (a == ADDR_WIDTH'(RAM_SIZE - 1)) return '0;
    return a + ADDR_WIDTH'(1);
  endfunction

  assign stride_ext = BRAM_ADDR_WIDTH'(stride_q);
  assign col_last   = (col_q == cols_q - DIM_WIDTH'(1));

  always_comb begin
    row_d      = row_q;
    col_d      = col_q;
    rows_d     = rows_q;
    cols_d     = cols_q;
    stride_d   = stride_q;
    row_base_d = row_base_q;
    src_addr_d = src_addr_q;
    dst_base_d = dst_base_q;
    dst_row_d  = dst_row_q;
    dst_col_d  = dst_col_q;
    xpose_d    = xpose_q;
    if (load_i) begin
      row_d      = '0;
      col_d      = '0;
      rows_d     = rows_i;
      cols_d     = cols_i;
      stride_d   = src_stride_i;
      row_base_d = src_base_i;
      src_addr_d = src_base_i;
      dst_base_d = dst_base_i;
      dst_row_d  = dst_base_i;
      dst_col_d  = dst_base_i;
      xpose_d    = xpose_i;
    end else if (step_i) begin
      if (col_last) begin
        col_d      = '0;
        row_d      = row_q + DIM_WIDTH'(1);
        row_base_d = row_base_q + stride_ext;
        src_addr_d = row_base_q + stride_ext;
        dst_row_d  = bank_inc(dst_row_q);
        dst_col_d  = dst_base_q;
      end else begin
        col_d      = col_q + DIM_WIDTH'(1);
        src_addr_d = src_addr_q + BRAM_ADDR_WIDTH'(1);
        dst_col_d  = bank_inc(dst_col_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_q      <= '0;
      col_q      <= '0;
      rows_q     <= '0;
      cols_q     <= '0;
      stride_q   <= '0;
      row_base_q <= '0;
      src_addr_q <= '0;
      dst_base_q <= '0;
      dst_row_q  <= '0;
      dst_col_q  <= '0;
      xpose_q    <= 1'b0;
    end else begin
      row_q      <= row_d;
      col_q      <= col_d;
      rows_q     <= rows_d;
      cols_q     <= cols_d;
      stride_q   <= stride_d;
      row_base_q <= row_base_d;
      src_addr_q <= src_addr_d;
      dst_base_q <= dst_base_d;
      dst_row_q  <= dst_row_d;
      dst_col_q  <= dst_col_d;
      xpose_q    <= xpose_d;
    end
  end

  assign src_addr_o = src_addr_q;
  assign dst_addr_o = xpose_q ? dst_col_q : dst_row_q;
  assign lane_o     = xpose_q ? row_q[LANE_W-1:0] : col_q[LANE_W-1:0];
  assign last_o     = col_last && (row_q == rows_q - DIM_WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/tile_loader.sv
`default_nettype none
// tile_loader: streams a row-major BRAM tile into ARRAY_N banked buffer RAMs.
// Optional transpose port under TILE_LOADER_TRANSPOSE_EN. Rev 1.0
module tile_loader
  import tile_loader_pkg::*;
#(
  parameter int ARRAY_N         = 16,
  parameter int RAM_SIZE        = 1024,
  parameter int ADDR_WIDTH      = $clog2(RAM_SIZE),
  parameter int BRAM_ADDR_WIDTH = 32,
  parameter int ELEM_WIDTH      = 8,
  parameter int DIM_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
`ifdef TILE_LOADER_TRANSPOSE_EN
  input  logic                       transpose,
`endif
  input  logic [BRAM_ADDR_WIDTH-1:0] src_base,
  input  logic [DIM_WIDTH-1:0]       src_stride,
  input  logic [ADDR_WIDTH-1:0]      dst_base,
  input  logic [DIM_WIDTH-1:0]       num_rows,
  input  logic [DIM_WIDTH-1:0]       num_cols,
  output logic                       bram_en,
  output logic [BRAM_ADDR_WIDTH-1:0] bram_addr,
  input  logic [31:0]                bram_rdata,
  output logic [ARRAY_N-1:0]         buf_w_en,
  output logic [ADDR_WIDTH-1:0]      buf_w_addr,
  output logic [31:0]                buf_w_data,
  output logic                       busy,
  output logic                       done
);

  localparam int LANE_W = (ARRAY_N > 1) ? $clog2(ARRAY_N) : 1;

  state_e                   state_q, state_d;
  logic [1:0]               drain_cnt_q, drain_cnt_d;
  logic                     p1_valid_q;
  logic [LANE_W-1:0]        p1_lane_q;
  logic [ADDR_WIDTH-1:0]    p1_addr_q;
  logic [ARRAY_N-1:0]       w_en_q;
  logic [ADDR_WIDTH-1:0]    w_addr_q;
  logic [31:0]              w_data_q;

  logic                     xpose_in;
  logic                     accept, zero_tile, load, step, last;
  logic [DIM_WIDTH-1:0]     rows_eff, cols_eff;
  logic [ADDR_WIDTH-1:0]    gen_dst_addr;
  logic [LANE_W-1:0]        gen_lane;
  logic                     rdata_unused;

`ifdef TILE_LOADER_TRANSPOSE_EN
  assign xpose_in = transpose;
`else
  assign xpose_in = 1'b0;
`endif

  // The lane dimension is the one limited to ARRAY_N; the other is unbounded.
  always_comb begin
    rows_eff = num_rows;
    cols_eff = num_cols;
    if (xpose_in) begin
      if (num_rows > DIM_WIDTH'(ARRAY_N)) rows_eff = DIM_WIDTH'(ARRAY_N);
    end else begin
      if (num_cols > DIM_WIDTH'(ARRAY_N)) cols_eff = DIM_WIDTH'(ARRAY_N);
    end
  end

  assign accept    = start && (state_q == IDLE);
  assign zero_tile = (num_rows == '0) || (num_cols == '0);
  assign load      = accept && !zero_tile;
  assign step      = (state_q == RUN);

  tile_addr_gen #(
    .ARRAY_N        (ARRAY_N),
    .RAM_SIZE       (RAM_SIZE),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .BRAM_ADDR_WIDTH(BRAM_ADDR_WIDTH),
    .DIM_WIDTH      (DIM_WIDTH),
    .LANE_W         (LANE_W)
  ) u_addr_gen (
    .clk         (clk),
    .reset       (reset),
    .load_i      (load),
    .step_i      (step),
    .xpose_i     (xpose_in),
    .src_base_i  (src_base),
    .src_stride_i(src_stride),
    .dst_base_i  (dst_base),
    .rows_i      (rows_eff),
    .cols_i      (cols_eff),
    .src_addr_o  (bram_addr),
    .dst_addr_o  (gen_dst_addr),
    .lane_o      (gen_lane),
    .last_o      (last)
  );

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = '0;
    case (state_q)
      IDLE:  if (start) state_d = zero_tile ? DONE : RUN;
      RUN:   if (last) state_d = DRAIN;
      DRAIN: begin
        drain_cnt_d = drain_cnt_q + 2'd1;
        if (drain_cnt_q == 2'(PIPE_LAT - 1)) state_d = DONE;
      end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      drain_cnt_q <= '0;
      p1_valid_q  <= 1'b0;
      p1_lane_q   <= '0;
      p1_addr_q   <= '0;
      w_en_q      <= '0;
      w_addr_q    <= '0;
      w_data_q    <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      // Stage 1 tracks the element whose BRAM data arrives next cycle.
      p1_valid_q  <= step;
      p1_lane_q   <= gen_lane;
      p1_addr_q   <= gen_dst_addr;
      w_en_q      <= p1_valid_q ? (ARRAY_N'(1) << p1_lane_q) : '0;
      if (p1_valid_q) begin
        w_addr_q <= p1_addr_q;
        w_data_q <= 32'(bram_rdata[ELEM_WIDTH-1:0]);
      end
    end
  end

  assign rdata_unused = ^bram_rdata[31:ELEM_WIDTH];

  assign bram_en    = (state_q == RUN);
  assign buf_w_en   = w_en_q;
  assign buf_w_addr = w_addr_q;
  assign buf_w_data = w_data_q;
  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign done       = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_tile_loader.sv
`default_nettype none
// tb_tile_loader: vector table plus read/write scoreboard queues for tile_loader.
// Rev 1.0
module tb_tile_loader;

  localparam int N  = 16;
  localparam int RS = 1024;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   src_base = '0;
  logic [15:0]   src_stride = '0;
  logic [AW-1:0] dst_base = '0;
  logic [15:0]   num_rows = '0;
  logic [15:0]   num_cols = '0;
  logic          bram_en;
  logic [31:0]   bram_addr;
  logic [31:0]   bram_rdata = '0;
  logic [N-1:0]  buf_w_en;
  logic [AW-1:0] buf_w_addr;
  logic [31:0]   buf_w_data;
  logic          busy;
  logic          done;

  tile_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .src_base  (src_base),
    .src_stride(src_stride),
    .dst_base  (dst_base),
    .num_rows  (num_rows),
    .num_cols  (num_cols),
    .bram_en   (bram_en),
    .bram_addr (bram_addr),
    .bram_rdata(bram_rdata),
    .buf_w_en  (buf_w_en),
    .buf_w_addr(buf_w_addr),
    .buf_w_data(buf_w_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] bram_word(input logic [31:0] a);
    return {a[23:0] ^ 24'hC3C3C3, a[7:0] ^ 8'hA5};
  endfunction

  always @(posedge clk) if (bram_en) bram_rdata <= bram_word(bram_addr);

  typedef struct {
    int          cyc;
    logic [31:0] addr;
  } rd_t;

  typedef struct {
    int            cyc;
    logic [N-1:0]  en;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct {
    int          rows;
    int          cols;
    logic [31:0] src;
    int          stride;
    int          dst;
    int          exp_n;
    int          exp_done;
  } vec_t;

  rd_t rdq[$];
  wr_t wrq[$];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  int c0 = 0;
  int n_t = 0;
  int exp_done_abs = 0;
  int done_seen = 0;
  int wr_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    rd_t r;
    wr_t w;
    if (mon_en) begin
      chk("busy", 64'(busy), 64'((n_t != 0) && (cyc >= c0 + 1) && (cyc <= c0 + n_t + 2)));
      if (bram_en) begin
        if (rdq.size() == 0) chk("extra_read", 64'(1), 64'(0));
        else begin
          r = rdq.pop_front();
          chk("rd_addr", 64'(bram_addr), 64'(r.addr));
          chk("rd_cycle", 64'(cyc), 64'(r.cyc));
        end
      end
      if (buf_w_en != '0) begin
        wr_seen++;
        if (wrq.size() == 0) chk("extra_write", 64'(1), 64'(0));
        else begin
          w = wrq.pop_front();
          chk("wr_en", 64'(buf_w_en), 64'(w.en));
          chk("wr_addr", 64'(buf_w_addr), 64'(w.addr));
          chk("wr_data", 64'(buf_w_data), 64'(w.data));
          chk("wr_cycle", 64'(cyc), 64'(w.cyc));
        end
      end
      if (done) begin
        done_seen++;
        chk("done_cycle", 64'(cyc), 64'(exp_done_abs));
      end
    end
  end

  task automatic run_tile(input vec_t v, input bit repulse);
    int n;
    int ccols;
    logic [31:0] a;
    logic [31:0] word;
    int done_before;
    @(negedge clk);
    c0 = cyc;
    ccols = (v.cols > N) ? N : v.cols;
    n = 0;
    rdq.delete();
    wrq.delete();
    for (int r = 0; r < v.rows; r++) begin
      for (int c = 0; c < ccols; c++) begin
        a = v.src + 32'(r) * 32'(v.stride) + 32'(c);
        word = bram_word(a);
        rdq.push_back('{cyc: c0 + 1 + n, addr: a});
        wrq.push_back('{cyc: c0 + 3 + n, en: N'(1) << c,
                        addr: AW'((v.dst + r) % RS), data: {24'b0, word[7:0]}});
        n++;
      end
    end
    n_t = n;
    exp_done_abs = c0 + v.exp_done;
    done_before = done_seen;
    wr_seen = 0;
    src_base = v.src;
    src_stride = 16'(v.stride);
    dst_base = AW'(v.dst);
    num_rows = 16'(v.rows);
    num_cols = 16'(v.cols);
    start = 1'b1;
    mon_en = 1'b1;
    for (int k = 1; k <= v.exp_done + 6; k++) begin
      @(negedge clk);
      start = repulse && (k == 2 || k == v.exp_done);
      if (k == 1) begin
        src_base = 32'hDEAD_0000;
        src_stride = 16'd77;
        dst_base = AW'(333);
        num_rows = 16'd9;
        num_cols = 16'd9;
      end
    end
    start = 1'b0;
    mon_en = 1'b0;
    chk("done_count", 64'(done_seen - done_before), 64'(1));
    chk("write_count", 64'(wr_seen), 64'(v.exp_n));
    chk("rdq_left", 64'(rdq.size()), 64'(0));
    chk("wrq_left", 64'(wrq.size()), 64'(0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bram_en"}, 64'(bram_en), 64'(0));
    chk({tag, "_bram_addr"}, 64'(bram_addr), 64'(0));
    chk({tag, "_w_en"}, 64'(buf_w_en), 64'(0));
    chk({tag, "_w_addr"}, 64'(buf_w_addr), 64'(0));
    chk({tag, "_w_data"}, 64'(buf_w_data), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{rows: 2, cols: 3,  src: 32'h100,       stride: 3,    dst: 5,    exp_n: 6,  exp_done: 9};
    vecs[1] = '{rows: 0, cols: 4,  src: 32'h200,       stride: 4,    dst: 0,    exp_n: 0,  exp_done: 1};
    vecs[2] = '{rows: 1, cols: 20, src: 32'h200,       stride: 20,   dst: 0,    exp_n: 16, exp_done: 19};
    vecs[3] = '{rows: 4, cols: 1,  src: 32'h300,       stride: 7,    dst: 1022, exp_n: 4,  exp_done: 7};
    vecs[4] = '{rows: 3, cols: 16, src: 32'hFFFF_FFF8, stride: 32,   dst: 100,  exp_n: 48, exp_done: 51};
    vecs[5] = '{rows: 5, cols: 0,  src: 32'h40,        stride: 1,    dst: 9,    exp_n: 0,  exp_done: 1};

    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;

    foreach (vecs[i]) run_tile(vecs[i], 1'b0);

    // Reset in the middle of a 4x4 tile, then a clean restart.
    @(negedge clk);
    src_base = 32'h400;
    src_stride = 16'd4;
    dst_base = AW'(10);
    num_rows = 16'd4;
    num_cols = 16'd4;
    start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 5) begin
        chk("pre_rst_w_en", 64'(buf_w_en), 64'h4);
        reset = 1'b1;
      end
    end
    @(negedge clk);
    chk_all_zero("midrst");
    reset = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("post_rst_w_en", 64'(buf_w_en), 64'(0));
      chk("post_rst_bram_en", 64'(bram_en), 64'(0));
    end
    run_tile('{rows: 4, cols: 4, src: 32'h400, stride: 4, dst: 10, exp_n: 16, exp_done: 19}, 1'b0);

    // start re-pulsed during RUN and on the done cycle must be ignored.
    run_tile('{rows: 2, cols: 3, src: 32'h500, stride: 5, dst: 40, exp_n: 6, exp_done: 9}, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
